// File: rtl/lsu.sv
// Load/store unit: one memory op at a time, valid/addr_ok/data_ok handshake to the data port.
// Latency: accept N, data_req N+1, resp_valid N+2 (combined ok) or N+3 (separate ok); misaligned N+1.
// Backpressure: busy stalls the pipe from the accept cycle until RESP; data_req held until data_addr_ok.
module lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [4:0]  ld_op,
   input  logic [2:0]  st_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_addr,
   output logic        busy,
   output logic        data_req,
   output logic        data_wr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        resp_valid,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        adel,
   output logic        ades
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t      state_q;
   logic [4:0]  ld_op_q;      // {lb, lbu, lh, lhu, lw}; all-zero means store
   logic [1:0]  addr_lo_q;
   logic [4:0]  rd_q;
   logic        data_req_q, data_wr_q;
   logic [3:0]  data_wstrb_q;
   logic [31:0] data_addr_q, data_wdata_q;
   logic        resp_valid_q, rf_we_q, adel_q, ades_q;
   logic [4:0]  rf_waddr_q;
   logic [31:0] rf_wdata_q;

   logic        accept, is_ld_in, misalign_in, load_q;
   logic [3:0]  data_wstrb_d;
   logic [31:0] data_wdata_d, rf_wdata_d;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Accept decode, alignment check and store lane formatting from the EX-stage inputs
   always_comb begin
      accept       = (state_q == S_IDLE) && req_valid && ((|ld_op) || (|st_op));
      is_ld_in     = |ld_op;
      data_wstrb_d = 4'b0000;
      data_wdata_d = 32'h0;
      if (is_ld_in) begin
         misalign_in = ((ld_op[2] | ld_op[1]) & addr[0]) | (ld_op[0] & (|addr[1:0]));
      end else begin
         misalign_in = (st_op[1] & addr[0]) | (st_op[0] & (|addr[1:0]));
         if (st_op[2]) begin
            data_wstrb_d = 4'b0001 << addr[1:0];
            data_wdata_d = {4{wdata[7:0]}};
         end else if (st_op[1]) begin
            data_wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
            data_wdata_d = {2{wdata[15:0]}};
         end else begin
            data_wstrb_d = 4'b1111;
            data_wdata_d = wdata;
         end
      end
   end

   // Load extraction from the returned word using the latched op and byte offset
   always_comb begin
      load_q   = |ld_op_q;
      byte_sel = data_rdata[{addr_lo_q, 3'b000} +: 8];
      half_sel = addr_lo_q[1] ? data_rdata[31:16] : data_rdata[15:0];
      if (ld_op_q[4])      rf_wdata_d = {{24{byte_sel[7]}}, byte_sel};
      else if (ld_op_q[3]) rf_wdata_d = {24'h0, byte_sel};
      else if (ld_op_q[2]) rf_wdata_d = {{16{half_sel[15]}}, half_sel};
      else if (ld_op_q[1]) rf_wdata_d = {16'h0, half_sel};
      else if (ld_op_q[0]) rf_wdata_d = data_rdata;
      else                 rf_wdata_d = 32'h0;
   end

   // Stall while a request is outstanding, including the cycle an op is accepted
   always_comb begin
      busy = (state_q == S_REQ) || (state_q == S_WAIT) || accept;
   end

   // Transaction FSM with latched op fields and registered port outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ld_op_q      <= 5'h0;
         addr_lo_q    <= 2'h0;
         rd_q         <= 5'h0;
         data_req_q   <= 1'b0;
         data_wr_q    <= 1'b0;
         data_wstrb_q <= 4'h0;
         data_addr_q  <= 32'h0;
         data_wdata_q <= 32'h0;
         resp_valid_q <= 1'b0;
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= 5'h0;
         rf_wdata_q   <= 32'h0;
         adel_q       <= 1'b0;
         ades_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  ld_op_q   <= ld_op;
                  addr_lo_q <= addr[1:0];
                  rd_q      <= rd_addr;
                  if (misalign_in) begin
                     // No memory traffic; report the fault straight away
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     adel_q       <= is_ld_in;
                     ades_q       <= ~is_ld_in;
                     rf_waddr_q   <= rd_addr;
                  end else begin
                     state_q      <= S_REQ;
                     data_req_q   <= 1'b1;
                     data_wr_q    <= ~is_ld_in;
                     data_wstrb_q <= data_wstrb_d;
                     data_addr_q  <= {addr[31:2], 2'b00};
                     data_wdata_q <= data_wdata_d;
                  end
               end
            end
            S_REQ: begin
               if (data_addr_ok) begin
                  data_req_q   <= 1'b0;
                  data_wr_q    <= 1'b0;
                  data_wstrb_q <= 4'h0;
                  data_addr_q  <= 32'h0;
                  data_wdata_q <= 32'h0;
                  if (data_data_ok) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     rf_we_q      <= load_q && (rd_q != 5'h0);
                     rf_waddr_q   <= rd_q;
                     rf_wdata_q   <= rf_wdata_d;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (data_data_ok) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  rf_we_q      <= load_q && (rd_q != 5'h0);
                  rf_waddr_q   <= rd_q;
                  rf_wdata_q   <= rf_wdata_d;
               end
            end
            default: begin
               // RESP lasts one cycle; new requests wait for IDLE
               state_q      <= S_IDLE;
               resp_valid_q <= 1'b0;
               rf_we_q      <= 1'b0;
               rf_waddr_q   <= 5'h0;
               rf_wdata_q   <= 32'h0;
               adel_q       <= 1'b0;
               ades_q       <= 1'b0;
            end
         endcase
      end
   end

   assign data_req   = data_req_q;
   assign data_wr    = data_wr_q;
   assign data_wstrb = data_wstrb_q;
   assign data_addr  = data_addr_q;
   assign data_wdata = data_wdata_q;
   assign resp_valid = resp_valid_q;
   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;
   assign adel       = adel_q;
   assign ades       = ades_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu with a transaction-level reference model.
// Ops are indexed 0..7 = lb, lbu, lh, lhu, lw, sb, sh, sw.
// A scripted memory responder applies addr_ok/data_ok delays and ignored-input noise.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [4:0]  ld_op;
   logic [2:0]  st_op;
   logic [31:0] addr, wdata;
   logic [4:0]  rd_addr;
   logic        busy, data_req, data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        resp_valid, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        adel, ades;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .ld_op(ld_op), .st_op(st_op),
      .addr(addr), .wdata(wdata), .rd_addr(rd_addr), .busy(busy),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .resp_valid(resp_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .adel(adel), .ades(ades)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid    = 1'b0;
      ld_op        = 5'h0;
      st_op        = 3'h0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = $urandom;
   endtask

   task automatic set_op(input int op);
      ld_op = (op < 5) ? (5'b10000 >> op) : 5'h0;
      st_op = (op >= 5) ? (3'b100 >> (op - 5)) : 3'h0;
   endtask

   // Request noise while the LSU is not in IDLE; must never be taken
   task automatic junk_req();
      req_valid = 1'b1;
      set_op(int'($urandom_range(0, 7)));
      addr    = $urandom;
      wdata   = $urandom;
      rd_addr = 5'($urandom);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_resp"}, {31'h0, resp_valid}, 0);
      chk({tag, "_rfwe"}, {31'h0, rf_we}, 0);
      chk({tag, "_req"}, {31'h0, data_req}, 0);
      chk({tag, "_wr"}, {31'h0, data_wr}, 0);
      chk({tag, "_strb"}, {28'h0, data_wstrb}, 0);
      chk({tag, "_daddr"}, data_addr, 0);
      chk({tag, "_dwdata"}, data_wdata, 0);
      chk({tag, "_waddr"}, {27'h0, rf_waddr}, 0);
      chk({tag, "_wdata"}, rf_wdata, 0);
      chk({tag, "_adel"}, {31'h0, adel}, 0);
      chk({tag, "_ades"}, {31'h0, ades}, 0);
   endtask

   // One full transaction: model expectation, drive, respond, check every cycle
   task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] rdat,
                         input int da, input int dd);
      int          size, lo;
      bit          is_ld, mis, exp_we;
      logic [31:0] exp_strb, exp_wd, exp_res, v;
      is_ld = (op < 5);
      size  = (op == 0 || op == 1 || op == 5) ? 1 : ((op == 4 || op == 7) ? 4 : 2);
      lo    = int'(a % 4);
      mis   = (a % size) != 0;
      exp_strb = 0;
      exp_wd   = 0;
      case (op)
         5: begin exp_strb = 32'(1 << lo); exp_wd = (wd & 255) * 32'h01010101; end
         6: begin exp_strb = (lo < 2) ? 3 : 12; exp_wd = (wd & 65535) * 32'h00010001; end
         7: begin exp_strb = 15; exp_wd = wd; end
         default: ;
      endcase
      case (op)
         0, 1: begin
            v = (rdat >> (8 * lo)) & 255;
            if (op == 0 && v >= 128) v = v + 32'hFFFFFF00;
         end
         2, 3: begin
            v = (rdat >> (16 * (lo / 2))) & 65535;
            if (op == 2 && v >= 32768) v = v + 32'hFFFF0000;
         end
         default: v = rdat;
      endcase
      exp_res = v;
      exp_we  = is_ld && !mis && (rd != 0);

      // accept cycle; memory inputs here must be ignored
      req_valid    = 1'b1;
      set_op(op);
      addr         = a;
      wdata        = wd;
      rd_addr      = rd;
      data_addr_ok = 1'($urandom);
      data_data_ok = 1'($urandom);
      data_rdata   = $urandom;
      #1;
      chk("busy_accept", {31'h0, busy}, 1);
      step();

      if (mis) begin
         junk_req();
         data_addr_ok = 1'($urandom);
         data_data_ok = 1'($urandom);
         #1;
         chk("mis_resp", {31'h0, resp_valid}, 1);
         chk("mis_adel", {31'h0, adel}, {31'h0, is_ld});
         chk("mis_ades", {31'h0, ades}, {31'h0, !is_ld});
         chk("mis_rfwe", {31'h0, rf_we}, 0);
         chk("mis_req", {31'h0, data_req}, 0);
         chk("mis_busy", {31'h0, busy}, 0);
      end else begin
         for (int i = 0; i <= da; i++) begin
            junk_req();
            data_addr_ok = (i == da);
            data_data_ok = (i == da) ? (dd == 0) : 1'($urandom);
            data_rdata   = (i == da && dd == 0) ? rdat : $urandom;
            #1;
            chk("req_vld", {31'h0, data_req}, 1);
            chk("req_wr", {31'h0, data_wr}, {31'h0, !is_ld});
            chk("req_strb", {28'h0, data_wstrb}, exp_strb);
            chk("req_addr", data_addr, a & 32'hFFFFFFFC);
            if (!is_ld) chk("req_wdata", data_wdata, exp_wd);
            chk("req_busy", {31'h0, busy}, 1);
            chk("req_noresp", {31'h0, resp_valid}, 0);
            step();
         end
         for (int j = 1; j <= dd; j++) begin
            junk_req();
            data_addr_ok = 1'($urandom);
            data_data_ok = (j == dd);
            data_rdata   = (j == dd) ? rdat : $urandom;
            #1;
            chk("wait_req", {31'h0, data_req}, 0);
            chk("wait_busy", {31'h0, busy}, 1);
            chk("wait_noresp", {31'h0, resp_valid}, 0);
            step();
         end
         // RESP: offer a valid request and stray acks, all to be ignored
         junk_req();
         data_addr_ok = 1'($urandom);
         data_data_ok = 1'($urandom);
         data_rdata   = $urandom;
         #1;
         chk("resp_vld", {31'h0, resp_valid}, 1);
         chk("resp_rfwe", {31'h0, rf_we}, {31'h0, exp_we});
         if (exp_we) begin
            chk("resp_waddr", {27'h0, rf_waddr}, {27'h0, rd});
            chk("resp_wdata", rf_wdata, exp_res);
         end
         chk("resp_adel", {31'h0, adel}, 0);
         chk("resp_ades", {31'h0, ades}, 0);
         chk("resp_busy", {31'h0, busy}, 0);
         chk("resp_req", {31'h0, data_req}, 0);
      end
      step();
      idle_inputs();
      #1;
      chk("post_resp", {31'h0, resp_valid}, 0);
      chk("post_req", {31'h0, data_req}, 0);
      chk("post_busy", {31'h0, busy}, 0);
      chk("post_rfwe", {31'h0, rf_we}, 0);
   endtask

   initial begin
      // reset overrides a simultaneous valid request
      rst = 1'b1;
      idle_inputs();
      req_valid = 1'b1;
      set_op(4);
      addr = 32'h40; wdata = 32'h0; rd_addr = 5'd3;
      step();
      step();
      check_all_zero("reset");
      rst = 1'b0;
      idle_inputs();
      step();

      // directed scenarios
      run_op(7, 32'h100, 32'hDEADBEEF, 5'd5, 32'h0, 0, 1);
      run_op(0, 32'h103, 32'h0, 5'd7, 32'h80FF1234, 0, 0);
      run_op(1, 32'h103, 32'h0, 5'd7, 32'h80FF1234, 0, 1);
      run_op(6, 32'h102, 32'h0000ABCD, 5'd1, 32'h0, 0, 0);
      run_op(4, 32'h101, 32'h0, 5'd9, 32'h0, 0, 0);
      run_op(2, 32'h200, 32'h0, 5'd12, 32'h1234F00D, 3, 2);
      run_op(4, 32'h300, 32'h0, 5'd0, 32'hCAFEF00D, 0, 0);

      // reset in WAIT abandons the op; late data_ok lands in IDLE
      req_valid = 1'b1;
      set_op(4);
      addr = 32'h300; rd_addr = 5'd4; wdata = 32'h0;
      step();
      idle_inputs();
      data_addr_ok = 1'b1;
      step();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      data_data_ok = 1'b1;
      data_rdata   = 32'h12345678;
      #1;
      chk("rstw_busy", {31'h0, busy}, 0);
      check_all_zero("rstw");
      step();
      idle_inputs();
      #1;
      check_all_zero("rstw2");

      // random traffic with ignored no-op requests in between
      for (int k = 0; k < 150; k++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         run_op(int'($urandom_range(0, 7)), a, $urandom, 5'($urandom), $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         req_valid = 1'b1;
         ld_op = 5'h0;
         st_op = 3'h0;
         addr  = $urandom;
         #1;
         chk("noop_busy", {31'h0, busy}, 0);
         step();
         idle_inputs();
         #1;
         chk("noop_req", {31'h0, data_req}, 0);
         chk("noop_resp", {31'h0, resp_valid}, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
